// File: rtl/borda_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : borda_event_scheduler
// Purpose  : Rising-edge event scheduler for a two-channel edge-detection
//            datapath. Each channel keeps a saturating count of pending
//            edges. Pending events are offered round-robin on one
//            valid/ready port. Each channel also has a sticky overflow flag.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous reset, active-low
//            entrada    - level inputs, bit i = channel i
//            enable     - 1 = count new edges, 0 = discard them
//            evt_ready  - consumer accepts the offered event
//            clear_ovf  - synchronous clear of both overflow flags
//            evt_valid  - event offered (registered)
//            evt_chan   - channel of the offered event (registered)
//            pending0/1 - per-channel pending counts
//            overflow   - sticky per-channel overflow flags
// Revision : 1.0 - initial release
// ============================================================================
module borda_event_scheduler #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       entrada,
  input  logic             enable,
  input  logic             evt_ready,
  input  logic             clear_ovf,
  output logic             evt_valid,
  output logic             evt_chan,
  output logic [CNT_W-1:0] pending0,
  output logic [CNT_W-1:0] pending1,
  output logic [1:0]       overflow
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_prev;
  logic [1:0]       w_rise;
  logic [CNT_W-1:0] r_cnt     [2];
  logic [CNT_W-1:0] w_cnt_nxt [2];
  logic [1:0]       w_ovf_set;
  logic [1:0]       r_ovf;
  logic             r_valid;
  logic             r_chan;
  logic             r_last_grant;
  logic             w_valid_nxt;
  logic             w_chan_nxt;
  logic             w_lg_nxt;
  logic             w_accept;

  // Round-robin pick: when both channels are pending, take the one that was
  // not granted last. Otherwise take whichever one is pending.
  function automatic logic arb(input logic nz0, input logic nz1, input logic lg);
    if (nz0 && nz1) return ~lg;
    else if (nz1)   return 1'b1;
    else            return 1'b0;
  endfunction

  assign w_rise   = entrada & ~r_prev;
  assign w_accept = r_valid & evt_ready;

  for (genvar i = 0; i < 2; i++) begin : g_chan
    logic w_inc;
    logic w_dec;
    logic w_at_max;

    assign w_inc    = w_rise[i] & enable;
    // A channel is only offered while its count is nonzero. The decrement
    // therefore never underflows.
    assign w_dec    = w_accept & (r_chan == 1'(i));
    assign w_at_max = (r_cnt[i] == {CNT_W{1'b1}});

    always_comb begin
      w_cnt_nxt[i] = r_cnt[i];
      w_ovf_set[i] = 1'b0;
      if (w_inc && !w_dec) begin
        if (w_at_max) w_ovf_set[i] = 1'b1;
        else          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
      end else if (w_dec && !w_inc) begin
        w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_chan_nxt  = r_chan;
    w_lg_nxt    = r_last_grant;
    case (r_state)
      S_IDLE: begin
        w_valid_nxt = 1'b0;
        if ((|r_cnt[0]) || (|r_cnt[1])) begin
          w_chan_nxt  = arb(|r_cnt[0], |r_cnt[1], r_last_grant);
          w_valid_nxt = 1'b1;
          w_state_nxt = S_OFFER;
        end
      end
      S_OFFER: begin
        w_valid_nxt = 1'b1;
        if (evt_ready) begin
          // Arbitrate on the post-update counts. The channel just accepted
          // becomes the new last grant.
          w_lg_nxt = r_chan;
          if ((|w_cnt_nxt[0]) || (|w_cnt_nxt[1])) begin
            w_chan_nxt = arb(|w_cnt_nxt[0], |w_cnt_nxt[1], r_chan);
          end else begin
            w_valid_nxt = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_prev       <= 2'b00;
      r_cnt[0]     <= '0;
      r_cnt[1]     <= '0;
      r_ovf        <= 2'b00;
      r_valid      <= 1'b0;
      r_chan       <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_prev       <= entrada;
      r_cnt[0]     <= w_cnt_nxt[0];
      r_cnt[1]     <= w_cnt_nxt[1];
      // If a flag is set in the same cycle as the clear, the set wins.
      r_ovf        <= clear_ovf ? w_ovf_set : (r_ovf | w_ovf_set);
      r_valid      <= w_valid_nxt;
      r_chan       <= w_chan_nxt;
      r_last_grant <= w_lg_nxt;
    end
  end

  assign evt_valid = r_valid;
  assign evt_chan  = r_chan;
  assign pending0  = r_cnt[0];
  assign pending1  = r_cnt[1];
  assign overflow  = r_ovf;

endmodule
`default_nettype wire
